param_deserializer_ctrl: RTL
============================

# param_deserializer_ctrl

Sequencing controller for nibble-serial to 32-bit word assembly in the bit-serial (4-bit) datapath. It accepts a start request carrying an access length and steps a subword index across 2, 4 or 8 incoming nibbles with valid/ready handshakes, writing each nibble into internal 8x4 subword storage. It then presents the assembled word, zero- or sign-extended, on a valid/ready output. It sits between the serial load/operand path and word-wide consumers such as writeback and CSR logic.

## Interface
- No parameters; widths are fixed: nibble 4, word 32, index 3.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start_val  in  1  request to begin a new assembly
- start_rdy  out  1  controller can accept a start
- start_len  in  2  0 = byte (2 nibbles), 1 = half (4), 2/3 = word (8)
- start_signed  in  1  sign-extend the result; present only when DESER_CTRL_SIGN_EXT_EN is defined
- nib_val  in  1  nibble valid
- nib_rdy  out  1  controller accepts a nibble
- nib_data  in  4  nibble, least-significant first
- word_val  out  1  assembled word valid
- word_rdy  in  1  consumer accepts the word
- word_data  out  32  assembled, extended word
- nib_idx  out  3  subword index of the next nibble write
- busy  out  1  state is not IDLE

## Operation
- Three states: IDLE, FILL, FULL. Reset enters IDLE with idx = 0, all storage = 0, and len/signed registers = 0.
- IDLE
  - start_rdy = 1.
  - When start_val && start_rdy: capture len and signed, clear all 8 subwords to 0, set idx = 0, go to FILL.
- FILL
  - nib_rdy = 1, start_rdy = 0.
  - When nib_val: write nib_data to subword[idx].
  - If idx == last, go to FULL; otherwise idx += 1.
  - last = 1, 3 or 7 for len 0, 1 or 2/3.
- FULL
  - word_val = 1, nib_rdy = 0, start_rdy = word_rdy.
  - word_rdy alone: go to IDLE, idx = 0.
  - word_rdy && start_val: take the start in the same cycle (capture, clear, idx = 0) and go directly to FILL.
- Handshakes fire only when val && rdy are both high in the same cycle.
  - nib_val outside FILL is ignored and no write occurs.
  - start_val in FILL is ignored.
  - A producer may hold val high indefinitely. Data must be stable while val && !rdy.
- word_data = {subword7..subword0} with extension applied above bit 4*(last+1)-1 (see Configuration). Contents are defined only while word_val = 1; in other states the field carries the raw storage.
- nib_idx = idx; busy = (state != IDLE).

## Timing
- Outputs start_rdy, nib_rdy, word_val and busy decode combinationally from the state register. No input-to-output combinational path exists except start_rdy from word_rdy in FULL.
- Reset values of outputs: start_rdy = 1, nib_rdy = 0, word_val = 0, busy = 0, nib_idx = 0, word_data = 0.
- Asynchronous reset mid-assembly drops the partial word without emitting anything; the first edge after release behaves as IDLE.
- Latency: start accepted at cycle 0 → FILL at cycle 1. With continuous nib_val, the last nibble is accepted at cycle N and word_val rises at cycle N+1 (N = 2, 4 or 8).
- Throughput with overlapped start in FULL: one word per N+1 cycles.
- A nibble written at the edge ending cycle t is visible on word_data from cycle t+1.
- idx never wraps past last. It resets to 0 only on start acceptance or on leaving FULL.

## Configuration
- DESER_CTRL_SIGN_EXT_EN
  - Defined: start_signed port exists and is captured at start. When the captured bit is 1, word_data bits above the last nibble replicate bit 4*(last+1)-1.
  - Undefined: the port is absent and the upper bits are always 0 (zero-extend).
  - Word length (len 2/3) is unaffected in both builds.

## Test plan
- Reset, then start len = 2, nibbles 1,2,...,8 back-to-back → word_val at cycle 9, word_data = 0x87654321, nib_idx sequence 0..7.
- Start len = 0, nibbles 0xA then 0xF:
  - with macro and signed = 1 → 0xFFFFFFFA_word = 0xFFFFFFFA; with signed = 0 → 0x000000FA.
  - without macro → 0x000000FA.
- Start len = 1, nib_val toggled 1,0,1,0 with nibbles 3,4,5,6 → writes only on valid cycles, word_data = 0x00006543 (unsigned); idx holds during bubbles.
- FULL with word_rdy = 0 for 5 cycles → word_val and word_data stable, nib_rdy = 0. Then word_rdy = 1 with start_val = 1 → FILL next cycle, storage reads 0.
- Assert reset_n = 0 after 3 of 8 nibbles → immediately busy = 0, start_rdy = 1. The next len = 0 transfer of 0x5, 0x6 → 0x00000065.
- nib_val = 1 in IDLE and start_val = 1 in FILL → no storage change, no state change.

Source files
------------

// File: rtl/param_deserializer_ctrl.sv
// param_deserializer_ctrl: steps a subword index across 2, 4 or 8 incoming
// nibbles (least-significant first), stores them in 8x4 subword storage and
// presents the assembled 32-bit word on a valid/ready output.
//
// Optional feature macro: DESER_CTRL_SIGN_EXT_EN
//   defined   -> start_signed port exists; byte/half results may be sign-extended
//   undefined -> no start_signed port; byte/half results are zero-extended
//
// Handshakes: a transfer happens on a rising clk edge exactly when the
// channel's val and rdy are both high; a producer may hold val high
// indefinitely and must keep its data stable while val && !rdy.
// The FSM state is fully observable as {word_val, nib_rdy, busy}.
module param_deserializer_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_val,
  output logic        start_rdy,
  input  logic [1:0]  start_len,
`ifdef DESER_CTRL_SIGN_EXT_EN
  input  logic        start_signed,
`endif
  input  logic        nib_val,
  output logic        nib_rdy,
  input  logic [3:0]  nib_data,
  output logic        word_val,
  input  logic        word_rdy,
  output logic [31:0] word_data,
  output logic [2:0]  nib_idx,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       idx;
  logic [7:0][3:0]  sub;
  logic [1:0]       len_q;
  logic             signed_q;
  logic             sgn_in;
  logic [2:0]       last;
  logic [31:0]      word_ext;

`ifdef DESER_CTRL_SIGN_EXT_EN
  assign sgn_in = start_signed;
`else
  assign sgn_in = 1'b0;
`endif

  // Index of the final nibble for the captured access length.
  assign last = (len_q == 2'd0) ? 3'd1 :
                (len_q == 2'd1) ? 3'd3 : 3'd7;

  // Handshake and status outputs decode straight from the state register;
  // the only input-to-output path is word_rdy -> start_rdy while FULL.
  assign start_rdy = (state == IDLE) || ((state == FULL) && word_rdy);
  assign nib_rdy   = (state == FILL);
  assign word_val  = (state == FULL);
  assign busy      = (state != IDLE);
  assign nib_idx   = idx;

  // Apply zero/sign extension above the last valid nibble.
  always_comb begin
    word_ext = sub;
    case (len_q)
      2'd0:    word_ext[31:8]  = {24{signed_q & sub[1][3]}};
      2'd1:    word_ext[31:16] = {16{signed_q & sub[3][3]}};
      default: word_ext        = sub;
    endcase
  end

  // Outside FULL the raw storage is shown.
  assign word_data = (state == FULL) ? word_ext : sub;

  // Sequencing FSM: start capture, nibble writes, word hand-off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= 3'd0;
      sub      <= '0;
      len_q    <= 2'd0;
      signed_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_val) begin
            len_q    <= start_len;
            signed_q <= sgn_in;
            sub      <= '0;
            idx      <= 3'd0;
            state    <= FILL;
          end
        end
        FILL: begin
          if (nib_val) begin
            sub[idx] <= nib_data;
            if (idx == last) begin
              state <= FULL;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        FULL: begin
          if (word_rdy) begin
            idx <= 3'd0;
            if (start_val) begin
              // Overlapped start: hand off the word and begin the next fill.
              len_q    <= start_len;
              signed_q <= sgn_in;
              sub      <= '0;
              state    <= FILL;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          idx   <= 3'd0;
        end
      endcase
    end
  end

endmodule
